msx_port_arbiter: RTL and testbench
===================================

Name: msx_port_arbiter

Overview:
- Owns the two MSX general-purpose ports (A/B) and shares port A between the digital joystick and the PS/2-derived mouse.
- Detects which device is in use, and arbitrates by activity with joystick priority.
- In mouse mode, sequences the 4-nibble MSX mouse readout on toggles of the port-A strobe (pin 8), with saturating delta accumulation and readout timeout.
- Sits between user_io (joystick/mouse) and emsx_top (pJoyA/pJoyB, pStra/pStrb) in the MSX top level.

Parameters:
- TIMEOUT, 100000: clk_sys cycles without a strobe toggle before the nibble sequencer returns to nibble 0.
- AF_HALF, 1073850: autofire half-period in clk_sys cycles (about 10 Hz at 21.477 MHz). Used only with JOY_AUTOFIRE_EN.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: synchronous, active-high; clock clk_sys.
- swap, in, 1: 1 routes joy1 to port A and joy0 to port B.
- joy0, in, 6: active-high {btnB, btnA, up, down, left, right}.
- joy1, in, 6: same encoding as joy0.
- mouse_x, in, 9: signed delta, positive = right.
- mouse_y, in, 9: signed delta, positive = up.
- mouse_btn, in, 2: active-high {right, left}.
- mouse_strobe, in, 1: one-cycle pulse; new delta and button values are valid.
- stra, in, 1: port A pin 8 driven by the MSX PPI/PSG.
- strb, in, 1: port B pin 8; reserved, ignored.
- porta_o, out, 6: active-low MSX order {trgB, trgA, right, left, down, up}; 1 = released.
- portb_o, out, 6: same encoding as porta_o.
- mouse_active, out, 1: 1 while port A is in MOUSE mode.

Behaviour:
- All outputs are registered. Reset values: porta_o = 6'h3F, portb_o = 6'h3F, mouse_active = 0, mode = JOY, seq = 0, accumulators = 0, stra_d = stra.
- Source select: jA = swap ? joy1 : joy0; jB = the other one.
  - portb_o <= ~{jB[5], jB[4], jB[0], jB[1], jB[2], jB[3]} every cycle, one-cycle latency.
- Mode FSM, two states:
  - JOY -> MOUSE on mouse_strobe when jA == 0.
  - MOUSE -> JOY when jA != 0.
  - If both happen in the same cycle, JOY wins.
  - Entering MOUSE clears seq to 0 and clears the accumulators.
- JOY mode: porta_o follows jA using the same mapping as port B.
- Accumulators, dx and dy, 8-bit signed:
  - On mouse_strobe: dx <= sat8(dx - mouse_x) (MSX X is negated) and dy <= sat8(dy + mouse_y).
  - Saturation range is -128..+127. Intermediate sums are computed in 10 bits.
  - mouse_strobe is honoured in any mode; the accumulators only matter in MOUSE mode.
- Toggle detection: stra_d <= stra each cycle; toggle = stra ^ stra_d.
- Nibble sequencer, MOUSE mode only, seq 0..3. On toggle, porta_o[3:0] is loaded the same cycle and is visible one cycle after the stra change:
  - seq 0: snapshot sx = dx, sy = dy; output sx[7:4]; clear dx/dy.
  - seq 1: output sx[3:0].
  - seq 2: output sy[7:4].
  - seq 3: output sy[3:0].
  - Nibble bit order onto porta_o[3:0] is {n[3], n[2], n[1], n[0]} -> {right, left, down, up}, i.e. n[0] goes to up.
  - Then seq <= seq + 1, wrapping 3 -> 0.
- Clear vs strobe: if the seq-0 clear coincides with mouse_strobe, the accumulator takes 0 plus the new delta, and no delta is lost.
- Timeout: a counter reloads to TIMEOUT on each toggle and decrements when nonzero. On the transition 1 -> 0, seq <= 0 and porta_o[3:0] holds its value.
- Mouse buttons: in MOUSE mode, porta_o[4] <= ~mouse_btn[0] and porta_o[5] <= ~mouse_btn[1], updated every cycle.
- Reset mid-readout: returns to JOY with seq = 0. No partial nibble survives.

Optional Feature:
- Macro: MSX_JOY_AUTOFIRE_EN.
- With the macro defined:
  - Adds input autofire [1:0] (bit 0 = port A, bit 1 = port B).
  - While the bit is set and the trgA source is held, trgA becomes a square wave with AF_HALF cycles pressed, then AF_HALF released, starting pressed on the press cycle.
  - Each port has an independent phase counter, reset on release.
  - Applies only in JOY mode.
- Without the macro: no autofire port and no counters; triggers pass through unchanged.

Test Plan:
- Reset, then joy0 = 6'h01 with swap = 0 -> porta_o = 6'h37 (right pressed) and portb_o = 6'h3F, one cycle after input.
- swap = 1, joy1 = 6'h10 -> porta_o = 6'h2F and portb_o = 6'h3F; set joy0 = 6'h08 -> portb_o = 6'h3E.
- mouse_strobe with x = +5, y = +3, then four stra toggles ≥10 cycles apart -> porta_o[3:0] sequence F, B, 0, 3 (dx = -5 = 8'hFB); mouse_active = 1.
- Ten strobes of x = -100 -> dx saturates at +127; readout nibbles 7, F for X.
- Two toggles, then no toggle for TIMEOUT + 5 cycles, then a toggle -> X high nibble is output again (seq restarted at 0).
- In MOUSE mode, joy0 up coincident with mouse_strobe -> mode = JOY, mouse_active = 0, porta_o = 6'h3E next cycle.

Source files
------------

// File: rtl/msx_port_arbiter_if.sv
// Device-side inputs and MSX-side port outputs of msx_port_arbiter.
// With MSX_JOY_AUTOFIRE_EN defined, an autofire[1:0] request is added.
interface msx_port_arbiter_if;
  logic       swap;
  logic [5:0] joy0;
  logic [5:0] joy1;
  logic [8:0] mouse_x;
  logic [8:0] mouse_y;
  logic [1:0] mouse_btn;
  logic       mouse_strobe;
  logic       stra;
  logic       strb;
  logic [5:0] porta_o;
  logic [5:0] portb_o;
  logic       mouse_active;
`ifdef MSX_JOY_AUTOFIRE_EN
  logic [1:0] autofire;

  modport master (
    output swap, joy0, joy1, mouse_x, mouse_y, mouse_btn, mouse_strobe,
    output stra, strb, autofire,
    input  porta_o, portb_o, mouse_active
  );

  modport slave (
    input  swap, joy0, joy1, mouse_x, mouse_y, mouse_btn, mouse_strobe,
    input  stra, strb, autofire,
    output porta_o, portb_o, mouse_active
  );
`else
  modport master (
    output swap, joy0, joy1, mouse_x, mouse_y, mouse_btn, mouse_strobe,
    output stra, strb,
    input  porta_o, portb_o, mouse_active
  );

  modport slave (
    input  swap, joy0, joy1, mouse_x, mouse_y, mouse_btn, mouse_strobe,
    input  stra, strb,
    output porta_o, portb_o, mouse_active
  );
`endif
endinterface

// File: rtl/msx_port_arbiter.sv
// MSX general-purpose port A/B arbiter: joystick pass-through, PS/2 mouse on port A
// with 4-nibble strobe readout. Optional trigger autofire under MSX_JOY_AUTOFIRE_EN.
module msx_port_arbiter #(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned AF_HALF = 1073850
) (
  input logic               clk_sys,
  input logic               reset,
  msx_port_arbiter_if.slave bus
);

  typedef enum logic {JOY, MOUSE} mode_e;

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  // {btnB, btnA, up, down, left, right} -> active-low {trgB, trgA, right, left, down, up}
  function automatic logic [5:0] msx_map(input logic [5:0] j);
    return ~{j[5], j[4], j[0], j[1], j[2], j[3]};
  endfunction

  function automatic logic [9:0] sext10(input logic [7:0] v);
    return {{2{v[7]}}, v};
  endfunction

  function automatic logic [7:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127)  return 8'h7F;
    if (v < -10'sd128) return 8'h80;
    return v[7:0];
  endfunction

  mode_e       mode_q, mode_d;
  logic [1:0]  seq_q, seq_d;
  logic [7:0]  dx_q, dx_d, dy_q, dy_d;
  logic [7:0]  sx_q, sy_q;
  logic [7:0]  dx_base, dy_base;
  logic [TW-1:0] to_q, to_d;
  logic        stra_q;
  logic [5:0]  porta_q, porta_d, portb_q, portb_d;
  logic        active_q;
  logic [5:0]  ja, jb, ja_eff, jb_eff;
  logic [1:0]  trg_eff;
  logic [3:0]  nib;
  logic        toggle, enter, load, clr;
  logic        unused_strb;

  assign unused_strb = bus.strb;

  always_comb begin
    ja = bus.swap ? bus.joy1 : bus.joy0;
    jb = bus.swap ? bus.joy0 : bus.joy1;
  end

`ifdef MSX_JOY_AUTOFIRE_EN
  localparam int unsigned AW = $clog2(AF_HALF + 1);

  logic [AW-1:0] af_cnt_q [2];
  logic [1:0]    af_ph_q;
  logic [1:0]    trg_held;

  assign trg_held = {jb[4], ja[4]};

  // Phase 0 is the pressed half, so a fresh press is seen pressed immediately.
  always_ff @(posedge clk_sys) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (reset || !trg_held[i] || !bus.autofire[i]) begin
        af_cnt_q[i] <= '0;
        af_ph_q[i]  <= 1'b0;
      end else if (af_cnt_q[i] == AW'(AF_HALF - 1)) begin
        af_cnt_q[i] <= '0;
        af_ph_q[i]  <= ~af_ph_q[i];
      end else begin
        af_cnt_q[i] <= af_cnt_q[i] + AW'(1);
      end
    end
  end

  assign trg_eff = trg_held & ~(bus.autofire & af_ph_q);
`else
  localparam int unsigned af_half_unused = AF_HALF;

  assign trg_eff = {jb[4], ja[4]};
`endif

  assign ja_eff = {ja[5], trg_eff[0], ja[3:0]};
  assign jb_eff = {jb[5], trg_eff[1], jb[3:0]};

  always_comb begin
    toggle = bus.stra ^ stra_q;
    mode_d = (ja != '0) ? JOY : (bus.mouse_strobe ? MOUSE : mode_q);
    enter  = (mode_q == JOY) && (mode_d == MOUSE);
    load   = (mode_q == MOUSE) && (mode_d == MOUSE) && toggle;

    // Clearing and a coincident strobe combine so that no delta is dropped.
    clr     = enter || (load && (seq_q == 2'd0));
    dx_base = clr ? '0 : dx_q;
    dy_base = clr ? '0 : dy_q;
    dx_d    = dx_base;
    dy_d    = dy_base;
    if (bus.mouse_strobe) begin
      dx_d = sat8(sext10(dx_base) - {bus.mouse_x[8], bus.mouse_x});
      dy_d = sat8(sext10(dy_base) + {bus.mouse_y[8], bus.mouse_y});
    end

    case (seq_q)
      2'd0:    nib = dx_q[7:4];
      2'd1:    nib = sx_q[3:0];
      2'd2:    nib = sy_q[7:4];
      default: nib = sy_q[3:0];
    endcase

    seq_d = seq_q;
    if (enter)                               seq_d = '0;
    else if (load)                           seq_d = seq_q + 2'd1;
    else if ((to_q == TW'(1)) && !toggle)    seq_d = '0;

    to_d = toggle ? TW'(TIMEOUT) : ((to_q != '0) ? to_q - TW'(1) : to_q);

    if (mode_d == JOY) porta_d = msx_map(ja_eff);
    else porta_d = {~bus.mouse_btn[1], ~bus.mouse_btn[0], load ? nib : porta_q[3:0]};
    portb_d = msx_map(jb_eff);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mode_q   <= JOY;
      seq_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      to_q     <= '0;
      stra_q   <= bus.stra;
      porta_q  <= '1;
      portb_q  <= '1;
      active_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      seq_q    <= seq_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      if (load && (seq_q == 2'd0)) begin
        sx_q <= dx_q;
        sy_q <= dy_q;
      end
      to_q     <= to_d;
      stra_q   <= bus.stra;
      porta_q  <= porta_d;
      portb_q  <= portb_d;
      active_q <= (mode_d == MOUSE);
    end
  end

  assign bus.porta_o      = porta_q;
  assign bus.portb_o      = portb_q;
  assign bus.mouse_active = active_q;

endmodule

// File: tb/tb_msx_port_arbiter.sv
// Directed scoreboard bench for msx_port_arbiter: joystick mapping, mouse readout,
// saturation, timeout, strobe/clear coincidence, mode exit and reset mid-readout.
module tb_msx_port_arbiter;
  localparam int unsigned TO = 200;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  msx_port_arbiter_if bus();

  msx_port_arbiter #(.TIMEOUT(TO), .AF_HALF(4)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    string      tag;
    int         kind;   // 0 porta, 1 portb, 2 mouse_active
    logic [5:0] val;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic push(input string tag, input int kind, input logic [5:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drain();
    exp_t e;
    logic [5:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = bus.porta_o;
        1:       obs = bus.portb_o;
        default: obs = {5'd0, bus.mouse_active};
      endcase
      n_checks++;
      assert (obs === e.val) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    tick();
    drain();
  endtask

  task automatic strobe_pulse(input int x, input int y);
    bus.mouse_x      = 9'(x);
    bus.mouse_y      = 9'(y);
    bus.mouse_strobe = 1'b1;
    step();
    bus.mouse_strobe = 1'b0;
    step();
  endtask

  task automatic toggle_exp(input string tag, input logic [3:0] n,
                            input bit stb = 1'b0, input int x = 0, input int y = 0);
    repeat (10) tick();
    bus.stra = ~bus.stra;
    if (stb) begin
      bus.mouse_x      = 9'(x);
      bus.mouse_y      = 9'(y);
      bus.mouse_strobe = 1'b1;
    end
    push(tag, 0, {2'b11, n});
    step();
    bus.mouse_strobe = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.swap = 1'b0; bus.joy0 = '0; bus.joy1 = '0;
    bus.mouse_x = '0; bus.mouse_y = '0; bus.mouse_btn = '0; bus.mouse_strobe = 1'b0;
    bus.stra = 1'b0; bus.strb = 1'b0;
`ifdef MSX_JOY_AUTOFIRE_EN
    bus.autofire = '0;
`endif
    tick(); tick();
    push("rst_porta", 0, 6'h3F); push("rst_portb", 1, 6'h3F); push("rst_active", 2, 6'h00);
    step();
    reset = 1'b0;

    bus.joy0 = 6'h01;
    push("joy0_right_a", 0, 6'h37); push("joy0_right_b", 1, 6'h3F);
    step();

    bus.swap = 1'b1; bus.joy0 = 6'h00; bus.joy1 = 6'h10;
    push("swap_trga_a", 0, 6'h2F); push("swap_trga_b", 1, 6'h3F);
    step();
    bus.joy0 = 6'h08;
    push("swap_up_b", 1, 6'h3E); push("swap_hold_a", 0, 6'h2F);
    step();

    bus.swap = 1'b0; bus.joy0 = '0; bus.joy1 = '0;
    push("idle_a", 0, 6'h3F); push("idle_active", 2, 6'h00);
    step();

    // Enter mouse mode; delta from the entering strobe is kept.
    push("enter_active", 2, 6'h01); push("enter_a", 0, 6'h3F);
    strobe_pulse(5, 3);
    toggle_exp("rd1_xh", 4'hF);
    toggle_exp("rd1_xl", 4'hB);
    toggle_exp("rd1_yh", 4'h0);
    toggle_exp("rd1_yl", 4'h3);

    bus.mouse_btn = 2'b01; push("btn_left", 0, 6'h23); step();
    bus.mouse_btn = 2'b10; push("btn_right", 0, 6'h13); step();
    bus.mouse_btn = 2'b00; push("btn_none", 0, 6'h33); step();
    bus.joy1 = 6'h20; push("mouse_portb", 1, 6'h1F); push("mouse_stay", 2, 6'h01); step();
    bus.joy1 = 6'h00; step();

    for (int i = 0; i < 10; i++) strobe_pulse(-100, 0);
    toggle_exp("satp_xh", 4'h7);
    toggle_exp("satp_xl", 4'hF);
    toggle_exp("satp_yh", 4'h0);
    toggle_exp("satp_yl", 4'h0);

    for (int i = 0; i < 10; i++) strobe_pulse(100, 100);
    toggle_exp("satn_xh", 4'h8);
    toggle_exp("satn_xl", 4'h0);
    toggle_exp("satn_yh", 4'h7);
    toggle_exp("satn_yl", 4'hF);

    // Timeout: a stalled readout restarts at the X high nibble.
    strobe_pulse(-8'sh12, 8'sh54);
    toggle_exp("to_xh", 4'h1);
    toggle_exp("to_xl", 4'h2);
    repeat (TO + 5) tick();
    strobe_pulse(-8'sh30, 0);
    toggle_exp("to_restart", 4'h3);
    toggle_exp("to_xl2", 4'h0);
    toggle_exp("to_yh2", 4'h0);
    toggle_exp("to_yl2", 4'h0);

    toggle_exp("cs_xh", 4'h0, 1'b1, -8'sh21, 5);
    toggle_exp("cs_xl", 4'h0);
    toggle_exp("cs_yh", 4'h0);
    toggle_exp("cs_yl", 4'h0);
    toggle_exp("cs_kept_xh", 4'h2);
    toggle_exp("cs_kept_xl", 4'h1);
    toggle_exp("cs_kept_yh", 4'h0);
    toggle_exp("cs_kept_yl", 4'h5);

    // Joystick activity beats a coincident mouse strobe.
    bus.joy0 = 6'h08; bus.mouse_x = '0; bus.mouse_y = '0; bus.mouse_strobe = 1'b1;
    push("exit_active", 2, 6'h00); push("exit_a", 0, 6'h3E);
    step();
    bus.mouse_strobe = 1'b0;
    bus.joy0 = 6'h00;
    push("exit_idle_a", 0, 6'h3F);
    step();

    push("re_enter_active", 2, 6'h01);
    strobe_pulse(-8'sh4A, 0);
    toggle_exp("pre_rst_xh", 4'h4);
    reset = 1'b1;
    tick(); tick();
    push("mid_rst_a", 0, 6'h3F); push("mid_rst_b", 1, 6'h3F); push("mid_rst_active", 2, 6'h00);
    step();
    reset = 1'b0;
    push("post_rst_active", 2, 6'h01);
    strobe_pulse(-8'sh70, 0);
    toggle_exp("post_rst_xh", 4'h7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
